// File: rtl/proj_hasher.sv
// rtl/proj_hasher.sv - MinHash element hasher and frame sequencer ahead of proj_sorter
module proj_hasher #(
    parameter int                INDICE_LEN    = 16,
    parameter int                SIGNATURE_LEN = 32,
    parameter int                COUNT_LEN     = 16,
    parameter logic [SIGNATURE_LEN-1:0] HASH_MULT = 32'h9E3779B1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [31:0]              in_seed,
    input  logic [COUNT_LEN-1:0]     in_num_elems,
    input  logic                     in_valid,
    input  logic [INDICE_LEN-1:0]    in_data,
    output logic                     in_ready,
    output logic [SIGNATURE_LEN-1:0] out_signature,
    output logic [INDICE_LEN-1:0]    out_index,
    output logic                     out_valid,
    output logic                     sort_clear_n,
    output logic                     end_sorting,
    output logic                     busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]               state;
    logic [SIGNATURE_LEN-1:0] seed_q;
    logic [COUNT_LEN-1:0]     num_q;
    logic [COUNT_LEN-1:0]     elem_cnt;
    logic [1:0]               drain_cnt;

    logic                     s1_valid;
    logic [SIGNATURE_LEN-1:0] s1_p;
    logic [INDICE_LEN-1:0]    s1_idx;

    logic                     hs;
    logic [SIGNATURE_LEN-1:0] h0;
    logic [SIGNATURE_LEN-1:0] p_next;
    logic [SIGNATURE_LEN-1:0] s_mix;
    logic [SIGNATURE_LEN-1:0] s_final;

    assign in_ready     = (state == S_RUN);
    assign hs           = in_valid & in_ready;
    assign sort_clear_n = rst_n & (state != S_CLEAR);
    assign end_sorting  = (state == S_DONE);
    assign busy         = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);

    assign h0      = {{(SIGNATURE_LEN-INDICE_LEN){1'b0}}, in_data} ^ seed_q;
    assign p_next  = h0 * HASH_MULT;
    assign s_mix   = s1_p ^ (s1_p >> 16);
    // All-ones is the idle filler and must never be produced by a real element
    assign s_final = (&s_mix) ? {{(SIGNATURE_LEN-1){1'b1}}, 1'b0} : s_mix;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            seed_q    <= '0;
            num_q     <= '0;
            elem_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_CLEAR;
                        seed_q   <= in_seed;
                        num_q    <= in_num_elems;
                        elem_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    state <= (num_q != '0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    if (hs) begin
                        elem_cnt <= elem_cnt + COUNT_LEN'(1);
                        if (elem_cnt == num_q - COUNT_LEN'(1)) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 2'd2;
                        end
                    end
                end
                S_DRAIN: begin
                    // Covers two hash stages plus the sorter's register and update
                    if (drain_cnt == 2'd0) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            out_valid     <= 1'b0;
            out_signature <= '1;
            out_index     <= '0;
        end else begin
            s1_valid      <= hs;
            out_valid     <= s1_valid;
            out_signature <= s1_valid ? s_final : '1;
            out_index     <= s1_valid ? s1_idx : '0;
        end
    end

    always_ff @(posedge clk) begin
        s1_p   <= p_next;
        s1_idx <= in_data;
    end

endmodule

// File: tb/tb_proj_hasher.sv
// tb/tb_proj_hasher.sv - directed self-checking bench for proj_hasher
module tb_proj_hasher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] in_seed;
    logic [15:0] in_num_elems;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [31:0] out_signature;
    logic [15:0] out_index;
    logic        out_valid;
    logic        sort_clear_n;
    logic        end_sorting;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    proj_hasher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_seed       (in_seed),
        .in_num_elems  (in_num_elems),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_signature (out_signature),
        .out_index     (out_index),
        .out_valid     (out_valid),
        .sort_clear_n  (sort_clear_n),
        .end_sorting   (end_sorting),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_hash(input logic [15:0] d, input logic [31:0] seed);
        logic [63:0] prod;
        logic [31:0] p;
        logic [31:0] s;
        prod = 64'({16'h0, d} ^ seed) * 64'h9E3779B1;
        p = prod[31:0];
        s = {p[31:16], p[15:0] ^ p[31:16]};
        if (s == 32'hFFFFFFFF) s = 32'hFFFFFFFE;
        return s;
    endfunction

    task automatic begin_frame(input logic [31:0] seed, input logic [15:0] num);
        start = 1'b1; in_seed = seed; in_num_elems = num;
        tick();
        start = 1'b0;
    endtask

    logic [4:0]  pat;
    logic [31:0] best_sig [4];
    logic [15:0] best_idx [4];
    logic [31:0] exp_sig  [4];
    logic [15:0] exp_idx  [4];
    int          n_hs;
    int          n_out;

    task automatic insert_best(input logic [31:0] sig, input logic [15:0] idx,
                               inout logic [31:0] bs [4], inout logic [15:0] bi [4]);
        logic [31:0] cs;
        logic [15:0] ci;
        logic [31:0] ts;
        logic [15:0] ti;
        cs = sig; ci = idx;
        for (int k = 0; k < 4; k++) begin
            if (cs < bs[k]) begin
                ts = bs[k]; ti = bi[k];
                bs[k] = cs; bi[k] = ci;
                cs = ts; ci = ti;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_seed = '0; in_num_elems = '0;
        in_valid = 1'b0; in_data = '0;
        tick(); tick();

        // reset state
        chk("rst_sig", out_signature, 32'hFFFFFFFF);
        chk("rst_idx", out_index, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_end", end_sorting, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clr_n", sort_clear_n, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_clr_n", sort_clear_n, 1);

        // test 1: seed 0, one element
        begin_frame(32'h0, 16'd1);
        chk("t1_clear_clr_n", sort_clear_n, 0);
        chk("t1_clear_busy", busy, 1);
        tick();
        chk("t1_run_ready", in_ready, 1);
        in_valid = 1'b1; in_data = 16'd1;
        tick();
        in_valid = 1'b0;
        chk("t1_ready_drop", in_ready, 0);
        chk("t1_n1_valid", out_valid, 0);
        tick();
        chk("t1_sig", out_signature, 32'h9E37E786);
        chk("t1_idx", out_index, 1);
        chk("t1_valid", out_valid, 1);
        tick();
        chk("t1_n3_end", end_sorting, 0);
        chk("t1_n3_fill", out_signature, 32'hFFFFFFFF);
        chk("t1_n3_valid", out_valid, 0);
        tick();
        chk("t1_n4_end", end_sorting, 1);
        chk("t1_n4_busy", busy, 0);

        // test 2: seed all-ones, back-to-back pair, restart from DONE
        begin_frame(32'hFFFFFFFF, 16'd2);
        chk("t2_clear_end", end_sorting, 0);
        chk("t2_clear_clr_n", sort_clear_n, 0);
        tick();
        in_valid = 1'b1; in_data = 16'd0;
        tick();
        chk("t2_ready2", in_ready, 1);
        in_data = 16'd1;
        tick();
        in_valid = 1'b0;
        chk("t2_ready_drop", in_ready, 0);
        chk("t2_sig0", out_signature, 32'h61C8E787);
        chk("t2_idx0", out_index, 0);
        chk("t2_valid0", out_valid, 1);
        tick();
        chk("t2_sig1", out_signature, ref_hash(16'd1, 32'hFFFFFFFF));
        chk("t2_sig1_const", out_signature, 32'hC391CF0F);
        chk("t2_idx1", out_index, 1);
        tick(); tick();
        chk("t2_end", end_sorting, 1);

        // test 3: valid toggling 1,0,1,0,1 for three elements
        pat = 5'b10101;
        n_hs = 0;
        begin_frame(32'h0, 16'd3);
        tick();
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 5) ? pat[i] : 1'b0;
            in_data  = 16'(10 + i);
            if (i >= 2 && i < 7 && pat[i-2]) begin
                chk($sformatf("t3_sig_c%0d", i), out_signature, ref_hash(16'(8 + i), 32'h0));
                chk($sformatf("t3_idx_c%0d", i), out_index, 16'(8 + i));
                chk($sformatf("t3_val_c%0d", i), out_valid, 1);
            end else begin
                chk($sformatf("t3_fill_c%0d", i), out_signature, 32'hFFFFFFFF);
                chk($sformatf("t3_fval_c%0d", i), out_valid, 0);
            end
            chk($sformatf("t3_end_c%0d", i), end_sorting, (i >= 8));
            if (in_valid && in_ready) n_hs++;
            tick();
        end
        in_valid = 1'b0;
        chk("t3_handshakes", n_hs, 3);

        // test 4: empty frame
        begin_frame(32'h5, 16'd0);
        in_valid = 1'b1;
        chk("t4_clear_clr_n", sort_clear_n, 0);
        chk("t4_clear_ready", in_ready, 0);
        tick();
        chk("t4_done_end", end_sorting, 1);
        chk("t4_done_clr_n", sort_clear_n, 1);
        chk("t4_done_ready", in_ready, 0);
        tick();
        chk("t4_hold_end", end_sorting, 1);
        chk("t4_hold_valid", out_valid, 0);
        in_valid = 1'b0;

        // test 5: start during RUN is ignored
        begin_frame(32'h0, 16'd2);
        tick();
        start = 1'b1; in_seed = 32'h12345678; in_num_elems = 16'd7;
        in_valid = 1'b1; in_data = 16'd5;
        tick();
        start = 1'b0;
        chk("t5_still_run", in_ready, 1);
        in_data = 16'd6;
        tick();
        in_valid = 1'b0;
        chk("t5_cnt_kept", in_ready, 0);
        chk("t5_sig0", out_signature, ref_hash(16'd5, 32'h0));
        tick();
        chk("t5_sig1", out_signature, ref_hash(16'd6, 32'h0));
        tick(); tick();
        chk("t5_end", end_sorting, 1);

        // test 5b: reset mid-RUN
        begin_frame(32'h0, 16'd5);
        tick();
        in_valid = 1'b1; in_data = 16'd3;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5b_clr_n_rst", sort_clear_n, 0);
        tick();
        chk("t5b_busy", busy, 0);
        chk("t5b_valid", out_valid, 0);
        chk("t5b_sig", out_signature, 32'hFFFFFFFF);
        chk("t5b_end", end_sorting, 0);
        chk("t5b_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("t5b_idle_busy", busy, 0);
        chk("t5b_idle_ready", in_ready, 0);

        // test 6: ten elements into a K=4 smallest tracker
        for (int k = 0; k < 4; k++) begin
            best_sig[k] = '1; best_idx[k] = '0;
            exp_sig[k]  = '1; exp_idx[k]  = '0;
        end
        for (int d = 0; d < 10; d++) insert_best(ref_hash(16'(d), 32'h0), 16'(d), exp_sig, exp_idx);
        n_out = 0;
        begin_frame(32'h0, 16'd10);
        tick();
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 10);
            in_data  = 16'(c);
            if (out_valid) begin
                n_out++;
                insert_best(out_signature, out_index, best_sig, best_idx);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("t6_outputs", n_out, 10);
        for (int k = 0; k < 4; k++) chk($sformatf("t6_rank%0d", k), best_idx[k], exp_idx[k]);
        chk("t6_idx0_first", best_idx[0], 0);
        chk("t6_end", end_sorting, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/proj_hasher.md
Name: proj_hasher

Overview:
- Upstream stage of proj_sorter in the MinHash datapath.
- Accepts a frame of element identifiers over a valid/ready stream and hashes each one with a per-frame seed into a SIGNATURE_LEN signature.
- Presents {signature, index} to the sorter every cycle.
- Sequences the sorter's per-frame clear and its end_sorting strobe, so the sorter holds the final K smallest indices when end_sorting rises.

Parameters:
- INDICE_LEN, 16, width of element identifier / index.
- SIGNATURE_LEN, 32, signature width; hash arithmetic below is defined for 32.
- COUNT_LEN, 16, width of frame element count.
- HASH_MULT, 32'h9E3779B1, odd multiplier of the hash.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  frame start pulse; samples in_seed and in_num_elems
- in_seed  in  32  per-frame hash seed
- in_num_elems  in  COUNT_LEN  elements in frame (0 allowed)
- in_valid  in  1  element valid
- in_data  in  INDICE_LEN  element identifier
- in_ready  out  1  element accepted when in_valid & in_ready
- out_signature  out  SIGNATURE_LEN  to sorter in_signature
- out_index  out  INDICE_LEN  to sorter in_index
- out_valid  out  1  out_signature/out_index carry a real element
- sort_clear_n  out  1  to sorter rst_n
- end_sorting  out  1  to sorter end_sorting
- busy  out  1  state != IDLE and state != DONE

Behaviour:
- Reset is rst_n, synchronous, active-low; clock is clk. Reset applies in any state, including mid-frame.
- Reset state:
  - FSM in IDLE; pipeline valids 0.
  - out_signature = all-ones; out_index = 0; out_valid = 0.
  - end_sorting = 0; in_ready = 0; busy = 0.
- sort_clear_n = rst_n & (state != CLEAR), combinational.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
  - IDLE/DONE with start=1 -> CLEAR. Seed and count are latched; element counter is zeroed.
  - start is ignored in CLEAR, RUN and DRAIN.
  - CLEAR (exactly 1 cycle) -> RUN if latched count != 0, else -> DONE.
  - RUN:
    - in_ready = 1 only in RUN.
    - Each handshake increments the counter.
    - A handshake with counter == count-1 -> DRAIN.
    - in_valid=0 cycles are stalls; no timeout.
  - DRAIN: 3-cycle down-counter, then -> DONE.
  - DONE: end_sorting = 1, held until next start/reset; end_sorting = 0 in all other states.
- end_sorting timing: if the last handshake is in cycle N, end_sorting is first high in cycle N+4. This covers 2 hash stages, the sorter's input register, and the sorter's update.
- Hash pipeline (no stall; sorter accepts every cycle):
  - Stage 0 (handshake cycle): h0 = zero_extend(in_data) XOR seed.
  - Stage 1 register: p = (h0 * HASH_MULT) mod 2^32.
  - Stage 2 output register: s = p XOR (p >> 16).
    - If s == 32'hFFFFFFFF, output 32'hFFFFFFFE. All-ones is reserved as the idle filler, which never wins the sorter's strict < compare.
  - out_index = in_data delayed 2 cycles.
- Latency: element handshaken in cycle N appears on outputs in cycle N+2 with out_valid=1.
- Idle filler: cycles with no real element drive out_signature = all-ones, out_index = 0, out_valid = 0.
- Boundary cases:
  - Back-to-back handshakes give one output per cycle.
  - in_valid during CLEAR/DRAIN/DONE is not accepted (in_ready=0).
  - start while end_sorting=1 restarts: end_sorting drops in the CLEAR cycle and the sorter is cleared.
  - Counter width COUNT_LEN; max frame 2^COUNT_LEN-1 elements.

Test Plan:
1. Reset, then start with seed=0, num=1; send data=1 -> cycle N+2: out_signature=32'h9E37E786, out_index=1, out_valid=1; end_sorting first high in N+4.
2. seed=32'hFFFFFFFF, num=2; send data=0 then data=1 back-to-back -> first signature=32'h61C8E787. Second signature matches a reference model. in_ready drops the cycle after the 2nd handshake.
3. seed=0, num=3, in_valid toggling 1,0,1,0,1 -> exactly 3 handshakes; filler cycles show all-ones/out_valid=0; end_sorting 4 cycles after 3rd handshake.
4. num=0 start -> sort_clear_n low 1 cycle; end_sorting high in cycle after CLEAR; in_ready never 1.
5. start pulsed during RUN -> ignored (counter, seed unchanged). rst_n=0 mid-RUN -> next cycle IDLE, out_valid=0, end_sorting=0, sort_clear_n=0 while reset low.
6. Integrated with proj_sorter (K=4), seed=0, data 0..9 -> sorter out_smallest_idx matches model of 4 smallest signatures (index 0 has signature 0, so it must be present).
